alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 4..64.
REQ-002 Derived constant SW = clog2(WIDTH), shift-amount width; not overridable.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 opcode  input  4  operation select (table REQ-012).
REQ-007 A, B  input  WIDTH each  signed two's-complement operands.
REQ-008 cin  input  1  carry-in, used by ADD only.
REQ-009 out_w  output  WIDTH  registered signed result, held until next completion.
REQ-010 zer, neg, cout, ovf, ill  output  1 each  registered flags: zero, sign, carry/no-borrow, signed overflow, illegal opcode.
REQ-011 busy, done  output  1 each  multi-cycle op in progress; one-cycle completion pulse.

Function
REQ-012 Opcodes: 0 ADD A+B+cin; 1 DBL (A<<<1)+B; 2 INC B+1; 3 SUBQ B-(B>>>2); 4 AND; 5 OR; 6 NOTB ~B; 7 ZERO; 8 SUB A-B; 9 MUL signed A*B; 10 SRA A>>>B[SW-1:0]; 11 SLL A<<B[SW-1:0]; 12-15 illegal.
REQ-013 FSM states IDLE, EXEC; IDLE->EXEC on accepted MUL, or SRA/SLL with nonzero shift amount; EXEC->IDLE on final step; all else stays IDLE.
REQ-014 Accept: start=1 and busy=0 at edge E0; A, B, cin, opcode captured at E0; later input changes have no effect on the accepted op.
REQ-015 Single-cycle ops (0-8, 12-15, shifts with amount 0): out_w and flags loaded at E0; done=1 for the cycle after E0; busy stays 0.
REQ-016 MUL: shift-add, one partial product per cycle; busy=1 from E0 through edge E(WIDTH); result and flags loaded at E(WIDTH), busy falls and done=1 for the following cycle.
REQ-017 SRA/SLL with amount k>0: one bit position per cycle; result loaded at edge Ek, busy falls and done=1 for the following cycle.
REQ-018 start while busy=1 is ignored, not queued; start on the done cycle is accepted normally.
REQ-019 Adder ops 0-3, 8: WIDTH-bit result wraps modulo 2^WIDTH; cout = unsigned carry out (SUB: 1 when A>=B unsigned); ovf = signed overflow of that sum.
REQ-020 MUL: out_w = low WIDTH bits of 2*WIDTH-bit signed product; ovf=1 when product not representable in WIDTH signed bits; cout=0.
REQ-021 Logical, shift, ZERO, illegal ops: cout=0, ovf=0; SLL shifts in zeros, SRA replicates sign bit.
REQ-022 Illegal opcode: out_w=0, ill=1, zer=1; ill cleared by next legal completion.
REQ-023 zer = (out_w==0), neg = out_w[WIDTH-1], both updated only when out_w loads.
REQ-024 Flags and out_w never change except at completion or reset; done never asserts without a prior accept.

Reset
REQ-025 rst_n=0 immediately forces: out_w=0, zer=1, neg=0, cout=0, ovf=0, ill=0, busy=0, done=0, FSM=IDLE, step counter and working registers cleared.
REQ-026 Reset during EXEC aborts the operation; no done pulse for it after release.
REQ-027 First accept possible on the first rising edge with rst_n=1.

Verification (WIDTH=16)
REQ-028 ADD A=0x7FFF, B=0x0001, cin=0 -> next cycle done=1, out_w=0x8000, neg=1, ovf=1, cout=0.
REQ-029 SUB A=0x0005, B=0x0005 -> out_w=0x0000, zer=1, cout=1, ovf=0, latency 1, busy never high.
REQ-030 MUL A=0xFFFD (-3), B=0x0007 -> busy high 16 cycles, then done=1, out_w=0xFFEB (-21), ovf=0; repeat with A=B=0x0100 -> out_w=0x0000, ovf=1, zer=1.
REQ-031 SRA A=0x8000, B=0x0004 -> done 4 cycles after accept, out_w=0xF800; start pulsed with ADD at cycle 2 is ignored, out_w unaffected.
REQ-032 MUL accepted, rst_n low at cycle 5 -> all outputs at reset values, no done after release; opcode 13 then -> out_w=0, ill=1, done after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle arithmetic/logic ops,
// shift-add signed multiply and bit-serial shifts.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] out_w,
  output logic             zer,
  output logic             neg,
  output logic             cout,
  output logic             ovf,
  output logic             ill,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam int PW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_DBL  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_SUBQ = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOTB = 4'd6;
  localparam logic [3:0] OP_ZERO = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLL  = 4'd11;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  typedef enum logic [1:0] {
    K_MUL,
    K_SRA,
    K_SLL
  } kind_t;

  state_t state_q, state_d;
  kind_t  kind_q;

  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] wrk_q;
  logic [CW-1:0]    cnt_q;

  logic [PW-1:0]    pp;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] shv;
  logic             mul_ovf;
  logic             last;

  logic [SW-1:0]    shamt;
  logic             go_mul;
  logic             go_sh;

  logic [WIDTH-1:0] ax, ay, res_c;
  logic [WIDTH:0]   asum;
  logic             ac, arith;
  logic             cout_c, ovf_c, ill_c;

  logic             cap_mul, cap_sh;
  logic             fin_load;
  logic [WIDTH-1:0] fin_val;
  logic             fin_cout, fin_ovf, fin_ill;

  assign busy   = (state_q == EXEC);
  assign shamt  = B[SW-1:0];
  assign go_mul = (opcode == OP_MUL);
  assign go_sh  = ((opcode == OP_SRA) || (opcode == OP_SLL))
                  && (shamt != '0);

  // Single-cycle datapath: every adder op becomes x + y + c
  always_comb begin
    ax    = A;
    ay    = B;
    ac    = cin;
    arith = 1'b0;
    res_c = '0;
    ill_c = 1'b0;
    case (opcode)
      OP_ADD:  arith = 1'b1;
      OP_DBL: begin
        ax    = A << 1;
        ac    = 1'b0;
        arith = 1'b1;
      end
      OP_INC: begin
        ax    = B;
        ay    = '0;
        ac    = 1'b1;
        arith = 1'b1;
      end
      OP_SUBQ: begin
        ax    = B;
        ay    = ~($signed(B) >>> 2);
        ac    = 1'b1;
        arith = 1'b1;
      end
      OP_SUB: begin
        ay    = ~B;
        ac    = 1'b1;
        arith = 1'b1;
      end
      OP_AND:  res_c = A & B;
      OP_OR:   res_c = A | B;
      OP_NOTB: res_c = ~B;
      OP_ZERO: res_c = '0;
      OP_MUL:  res_c = '0;
      OP_SRA:  res_c = A;
      OP_SLL:  res_c = A;
      default: ill_c = 1'b1;
    endcase
    asum   = {1'b0, ax} + {1'b0, ay}
             + {{WIDTH{1'b0}}, ac};
    cout_c = arith & asum[WIDTH];
    ovf_c  = arith & (ax[WIDTH-1] == ay[WIDTH-1])
             & (asum[WIDTH-1] != ax[WIDTH-1]);
    if (arith) res_c = asum[WIDTH-1:0];
  end

  // Sign bit of the multiplier carries negative weight
  assign pp   = wrk_q[0] ? mcand_q : '0;
  assign prod = (cnt_q == CW'(WIDTH - 1))
                ? acc_q - pp : acc_q + pp;
  assign mul_ovf = !((&prod[PW-1:WIDTH-1])
                     || !(|prod[PW-1:WIDTH-1]));

  assign shv = (kind_q == K_SRA)
               ? {wrk_q[WIDTH-1], wrk_q[WIDTH-1:1]}
               : {wrk_q[WIDTH-2:0], 1'b0};

  always_comb begin
    case (kind_q)
      K_MUL:   last = (cnt_q == CW'(WIDTH - 1));
      K_SRA,
      K_SLL:   last = (cnt_q == CW'(1));
      default: last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cap_mul  = 1'b0;
    cap_sh   = 1'b0;
    fin_load = 1'b0;
    fin_val  = res_c;
    fin_cout = cout_c;
    fin_ovf  = ovf_c;
    fin_ill  = ill_c;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            go_mul: begin
              cap_mul = 1'b1;
              state_d = EXEC;
            end
            go_sh: begin
              cap_sh  = 1'b1;
              state_d = EXEC;
            end
            default: fin_load = 1'b1;
          endcase
        end
      end
      EXEC: begin
        if (last) begin
          state_d  = IDLE;
          fin_load = 1'b1;
          fin_cout = 1'b0;
          fin_ill  = 1'b0;
          if (kind_q == K_MUL) begin
            fin_val = prod[WIDTH-1:0];
            fin_ovf = mul_ovf;
          end else begin
            fin_val = shv;
            fin_ovf = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      wrk_q   <= '0;
      cnt_q   <= '0;
      kind_q  <= K_MUL;
    end else if (cap_mul) begin
      acc_q   <= '0;
      mcand_q <= {{WIDTH{A[WIDTH-1]}}, A};
      wrk_q   <= B;
      cnt_q   <= '0;
      kind_q  <= K_MUL;
    end else if (cap_sh) begin
      wrk_q   <= A;
      cnt_q   <= {1'b0, shamt};
      kind_q  <= (opcode == OP_SRA) ? K_SRA : K_SLL;
    end else if (busy) begin
      if (kind_q == K_MUL) begin
        acc_q   <= prod;
        mcand_q <= mcand_q << 1;
        wrk_q   <= wrk_q >> 1;
        cnt_q   <= cnt_q + CW'(1);
      end else begin
        wrk_q   <= shv;
        cnt_q   <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_w <= '0;
      zer   <= 1'b1;
      neg   <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      ill   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= fin_load;
      if (fin_load) begin
        out_w <= fin_val;
        zer   <= (fin_val == '0);
        neg   <= fin_val[WIDTH-1];
        cout  <= fin_cout;
        ovf   <= fin_ovf;
        ill   <= fin_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq
// against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   opcode = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         cin = 1'b0;
  logic [W-1:0] out_w;
  logic         zer, neg, cout, ovf, ill, busy, done;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] prev_out = '0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opcode(opcode), .A(A), .B(B), .cin(cin),
    .out_w(out_w), .zer(zer), .neg(neg),
    .cout(cout), .ovf(ovf), .ill(ill),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic void model(
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    output logic [W-1:0] r,
    output logic         co,
    output logic         ov,
    output logic         il,
    output int           lat);
    longint sa, sb, ua, ub, cc, s, x, y;
    int k;
    bit ar;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    cc = longint'(c);
    k  = int'(b[3:0]);
    r = '0; co = 0; ov = 0; il = 0; lat = 0;
    s = 0; ar = 0;
    case (op)
      4'd0: begin
        s = sa + sb + cc; co = (ua + ub + cc) > 65535; ar = 1;
      end
      4'd1: begin
        x = (ua * 2) % 65536;
        y = (x > 32767) ? x - 65536 : x;
        s = y + sb; co = (x + ub) > 65535; ar = 1;
      end
      4'd2: begin
        s = sb + 1; co = (ub == 65535); ar = 1;
      end
      4'd3: begin
        y = sb >>> 2;
        s = sb - y; co = ub >= (y & 65535); ar = 1;
      end
      4'd8: begin
        s = sa - sb; co = ua >= ub; ar = 1;
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = ~b;
      4'd7: r = '0;
      4'd9: begin
        s = sa * sb; ar = 1; lat = W;
      end
      4'd10: begin
        r = W'($signed(a) >>> k); lat = k;
      end
      4'd11: begin
        r = a << k; lat = k;
      end
      default: il = 1;
    endcase
    if (ar) begin
      r  = s[W-1:0];
      ov = (s > 32767) || (s < -32768);
    end
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c,
                        input bit poke);
    logic [W-1:0] er;
    logic eco, eov, eil;
    int lat, n;
    bit hold;
    model(op, a, b, c, er, eco, eov, eil, lat);
    opcode = op; A = a; B = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    cin = 1'($urandom); opcode = 4'($urandom);
    chk($sformatf("busy_e0_op%0d", op), 64'(busy), 64'(lat > 0));
    n = 0;
    hold = 1;
    while (!done && n < 40) begin
      if (out_w !== prev_out) hold = 0;
      if (poke && n == 1) begin
        start = 1'b1; opcode = 4'd0; A = 16'h0001; B = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk($sformatf("latency_op%0d", op), 64'(n), 64'(lat));
    if (lat > 0) chk("hold_busy", 64'(hold), 64'(1));
    chk($sformatf("out_op%0d", op), 64'(out_w), 64'(er));
    chk("zer", 64'(zer), 64'(er == '0));
    chk("neg", 64'(neg), 64'(er[W-1]));
    chk("cout", 64'(cout), 64'(eco));
    chk("ovf", 64'(ovf), 64'(eov));
    chk("ill", 64'(ill), 64'(eil));
    chk("busy_done", 64'(busy), 64'(0));
    prev_out = er;
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'(0));
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 64'({out_w, zer, neg, cout, ovf, ill, busy, done}),
        64'({16'h0000, 7'b1000000}));
  endtask

  initial begin
    bit saw;
    logic [3:0] rop;
    #7;
    chk_reset("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd0, 16'h7FFF, 16'h0001, 1'b0, 0);
    chk("add_hex", 64'(out_w), 64'(16'h8000));
    chk("add_ovf", 64'(ovf), 64'(1));

    run_op(4'd8, 16'h0005, 16'h0005, 1'b0, 0);
    chk("sub_cout", 64'(cout), 64'(1));

    run_op(4'd9, 16'hFFFD, 16'h0007, 1'b0, 0);
    chk("mul_hex", 64'(out_w), 64'(16'hFFEB));

    run_op(4'd9, 16'h0100, 16'h0100, 1'b0, 0);
    chk("mul_big_ovf", 64'({ovf, zer}), 64'(2'b11));

    run_op(4'd10, 16'h8000, 16'h0004, 1'b0, 1);
    chk("sra_hex", 64'(out_w), 64'(16'hF800));

    run_op(4'd11, 16'h0003, 16'h0000, 1'b0, 0);
    run_op(4'd2, 16'h0000, 16'h7FFF, 1'b0, 0);
    run_op(4'd3, 16'h0000, 16'h8000, 1'b0, 0);
    run_op(4'd1, 16'h4000, 16'h0001, 1'b1, 0);
    run_op(4'd15, 16'h1234, 16'h5678, 1'b0, 0);
    run_op(4'd6, 16'h0000, 16'h00FF, 1'b0, 0);

    // Abort a multiply with reset
    opcode = 4'd9; A = 16'h0003; B = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("reset_mid_mul");
    prev_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) saw = 1;
    end
    chk("no_done_after_abort", 64'(saw), 64'(0));
    run_op(4'd13, 16'hAAAA, 16'h5555, 1'b1, 0);
    chk("ill_hex", 64'({out_w, ill}), 64'({16'h0000, 1'b1}));

    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_op(rop, W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
